// File: rtl/csi2tx_packet_buffer_wr.sv
// Write side of the CSI-2 TX packet buffer: stores aligned packet words into the RAM,
// commits whole packets, rewinds on overflow/abort and tracks the stored packet count.
module csi2tx_packet_buffer_wr #(
    parameter int unsigned ADDR_W       = 9,
    parameter int unsigned AFULL_MARGIN = 16
) (
    input  logic              clk_csi,
    input  logic              clk_csi_rst_n,
    input  logic              forcetxstopmode,
    input  logic [63:0]       pixel_data64,
    input  logic              pixel_data64_valid,
    input  logic              packet_incr_pulse,
    input  logic [ADDR_W:0]   rd_ptr,
    input  logic              pkt_rd_done,
    input  logic              err_clr,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [63:0]       mem_wr_data,
    output logic [ADDR_W:0]   commit_ptr,
    output logic [7:0]        pkt_count,
    output logic              pkt_avail,
    output logic              buf_full,
    output logic              buf_afull,
    output logic              overflow_err
);

    localparam int unsigned PTR_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [PTR_W-1:0] DEPTH_P  = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] MARGIN_P = PTR_W'(AFULL_MARGIN);
    localparam logic [7:0]       CNT_MAX  = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  w_wr_ptr_nxt;
    logic [PTR_W-1:0]  r_commit_ptr;
    logic [PTR_W-1:0]  w_commit_nxt;
    logic [7:0]        r_pkt_count;
    logic [7:0]        w_cnt_nxt;
    logic              r_pkt_avail;
    logic              r_overflow;
    logic              r_mem_wr_en;
    logic [ADDR_W-1:0] r_mem_wr_addr;
    logic [63:0]       r_mem_wr_data;
    logic              w_wr_go;
    logic              w_commit_go;
    logic              w_ovf_set;
    logic              w_dec;
    logic [PTR_W-1:0]  w_level;
    logic [PTR_W-1:0]  w_free;
    logic              w_buf_full;

    // Occupancy is measured against the reader pointer, including uncommitted words.
    assign w_level    = r_wr_ptr - rd_ptr;
    assign w_free     = DEPTH_P - w_level;
    assign w_buf_full = (w_level == DEPTH_P);

    // Packet write FSM: next state, pointer updates and event strobes.
    always_comb begin
        w_state_nxt  = r_state;
        w_wr_ptr_nxt = r_wr_ptr;
        w_commit_nxt = r_commit_ptr;
        w_wr_go      = 1'b0;
        w_commit_go  = 1'b0;
        w_ovf_set    = 1'b0;
        if (forcetxstopmode) begin
            w_wr_ptr_nxt = r_commit_ptr;
            w_state_nxt  = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (pixel_data64_valid) begin
                        if (!w_buf_full) begin
                            w_wr_go      = 1'b1;
                            w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
                            w_state_nxt  = S_WRITE;
                        end else begin
                            w_ovf_set   = 1'b1;
                            w_state_nxt = packet_incr_pulse ? S_IDLE : S_DROP;
                        end
                    end
                end
                S_WRITE: begin
                    if (pixel_data64_valid) begin
                        if (!w_buf_full) begin
                            w_wr_go      = 1'b1;
                            w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
                        end else begin
                            w_wr_ptr_nxt = r_commit_ptr;
                            w_ovf_set    = 1'b1;
                        end
                    end
                    if (packet_incr_pulse) begin
                        w_state_nxt = S_IDLE;
                        if (!w_ovf_set) begin
                            w_commit_nxt = w_wr_ptr_nxt;
                            w_commit_go  = 1'b1;
                        end
                    end else if (w_ovf_set) begin
                        w_state_nxt = S_DROP;
                    end
                end
                S_DROP: begin
                    if (packet_incr_pulse) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Packet count: a commit and a read in the same cycle cancel out.
    always_comb begin
        w_dec     = pkt_rd_done && (r_pkt_count != 8'd0);
        w_cnt_nxt = r_pkt_count;
        if (w_commit_go && !w_dec) begin
            if (r_pkt_count != CNT_MAX) begin
                w_cnt_nxt = r_pkt_count + 8'd1;
            end
        end else if (w_dec && !w_commit_go) begin
            w_cnt_nxt = r_pkt_count - 8'd1;
        end
    end

    always_ff @(posedge clk_csi or negedge clk_csi_rst_n) begin
        if (!clk_csi_rst_n) begin
            r_state       <= S_IDLE;
            r_wr_ptr      <= '0;
            r_commit_ptr  <= '0;
            r_pkt_count   <= '0;
            r_pkt_avail   <= 1'b0;
            r_overflow    <= 1'b0;
            r_mem_wr_en   <= 1'b0;
            r_mem_wr_addr <= '0;
            r_mem_wr_data <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_commit_ptr <= w_commit_nxt;
            r_pkt_count  <= w_cnt_nxt;
            r_pkt_avail  <= (w_cnt_nxt != 8'd0);
            r_mem_wr_en  <= w_wr_go;
            if (w_wr_go) begin
                r_mem_wr_addr <= r_wr_ptr[ADDR_W-1:0];
                r_mem_wr_data <= pixel_data64;
            end
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign mem_wr_en    = r_mem_wr_en;
    assign mem_wr_addr  = r_mem_wr_addr;
    assign mem_wr_data  = r_mem_wr_data;
    assign commit_ptr   = r_commit_ptr;
    assign pkt_count    = r_pkt_count;
    assign pkt_avail    = r_pkt_avail;
    assign overflow_err = r_overflow;
    assign buf_full     = w_buf_full;
    assign buf_afull    = (w_free <= MARGIN_P);

endmodule

// File: tb/tb_csi2tx_packet_buffer_wr.sv
// Scoreboard bench for csi2tx_packet_buffer_wr (ADDR_W=4, AFULL_MARGIN=2):
// directed scenarios followed by randomized packet traffic against a packet-level model.
module tb_csi2tx_packet_buffer_wr;

    logic        clk_csi = 1'b0;
    logic        clk_csi_rst_n = 1'b0;
    logic        forcetxstopmode = 1'b0;
    logic [63:0] pixel_data64 = '0;
    logic        pixel_data64_valid = 1'b0;
    logic        packet_incr_pulse = 1'b0;
    logic [4:0]  rd_ptr = '0;
    logic        pkt_rd_done = 1'b0;
    logic        err_clr = 1'b0;
    logic        mem_wr_en;
    logic [3:0]  mem_wr_addr;
    logic [63:0] mem_wr_data;
    logic [4:0]  commit_ptr;
    logic [7:0]  pkt_count;
    logic        pkt_avail;
    logic        buf_full;
    logic        buf_afull;
    logic        overflow_err;

    csi2tx_packet_buffer_wr #(.ADDR_W(4), .AFULL_MARGIN(2)) dut (
        .clk_csi(clk_csi), .clk_csi_rst_n(clk_csi_rst_n), .forcetxstopmode(forcetxstopmode),
        .pixel_data64(pixel_data64), .pixel_data64_valid(pixel_data64_valid),
        .packet_incr_pulse(packet_incr_pulse), .rd_ptr(rd_ptr), .pkt_rd_done(pkt_rd_done),
        .err_clr(err_clr), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .commit_ptr(commit_ptr), .pkt_count(pkt_count),
        .pkt_avail(pkt_avail), .buf_full(buf_full), .buf_afull(buf_afull),
        .overflow_err(overflow_err)
    );

    always #5 clk_csi = ~clk_csi;

    typedef struct {
        logic       we;
        logic [4:0] commit;
        logic [7:0] cnt;
        logic       avail;
        logic       full;
        logic       afull;
        logic       ovf;
    } st_t;
    typedef struct {
        logic [3:0]  addr;
        logic [63:0] data;
    } wr_t;

    st_t        sq[$];
    wr_t        wq[$];
    logic [4:0] ends[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Model: committed end, words of the open packet, drop flag, stored packets.
    logic [4:0] m_commit;
    int         m_pend;
    bit         m_drop;
    int         m_cnt;
    bit         m_ovf;
    logic [4:0] tb_rd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_commit = '0;
        m_pend   = 0;
        m_drop   = 0;
        m_cnt    = 0;
        m_ovf    = 0;
        tb_rd    = '0;
        sq.delete();
        wq.delete();
        ends.delete();
    endtask

    // One clock of stimulus; the model's expected response is queued for the monitor.
    task automatic cycle(input logic v, input logic [63:0] d, input logic pl, input logic fs,
                         input logic rdd, input logic [4:0] rd, input logic clr);
        logic [4:0] wr;
        logic [4:0] lvl;
        bit         full;
        bit         was_open;
        bit         oset;
        bit         we;
        bit         cevt;
        st_t        s;
        @(negedge clk_csi);
        pixel_data64_valid = v;
        pixel_data64       = d;
        packet_incr_pulse  = pl;
        forcetxstopmode    = fs;
        pkt_rd_done        = rdd;
        rd_ptr             = rd;
        err_clr            = clr;
        tb_rd              = rd;

        wr       = m_commit + 5'(m_pend);
        lvl      = wr - rd;
        full     = (lvl == 5'd16);
        was_open = (m_pend != 0);
        oset = 0; we = 0; cevt = 0;
        if (fs) begin
            m_pend = 0;
            m_drop = 0;
        end else if (m_drop) begin
            if (pl) m_drop = 0;
        end else begin
            if (v) begin
                if (full) begin
                    oset   = 1;
                    m_pend = 0;
                    m_drop = !pl;
                end else begin
                    we = 1;
                    wq.push_back('{addr: wr[3:0], data: d});
                    m_pend++;
                end
            end
            if (pl && was_open && !oset) begin
                m_commit = m_commit + 5'(m_pend);
                m_pend   = 0;
                cevt     = 1;
                ends.push_back(m_commit);
            end
        end
        if (cevt && !(rdd && m_cnt != 0)) begin
            if (m_cnt < 255) m_cnt++;
        end else if (!cevt && rdd && m_cnt != 0) begin
            m_cnt--;
        end
        if (oset) m_ovf = 1;
        else if (clr) m_ovf = 0;

        lvl     = (m_commit + 5'(m_pend)) - rd;
        s.we     = we;
        s.commit = m_commit;
        s.cnt    = 8'(m_cnt);
        s.avail  = (m_cnt != 0);
        s.full   = (lvl == 5'd16);
        s.afull  = ((5'd16 - lvl) <= 5'd2);
        s.ovf    = m_ovf;
        sq.push_back(s);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, '0, 0, 0, 0, tb_rd, 0);
    endtask

    task automatic word();
        cycle(1, {$urandom, $urandom}, 0, 0, 0, tb_rd, 0);
    endtask

    task automatic settle();
        @(posedge clk_csi);
        #2;
    endtask

    // Asserts reset between edges and checks the outputs before any clock.
    task automatic do_reset();
        settle();
        pixel_data64_valid = 0;
        packet_incr_pulse  = 0;
        forcetxstopmode    = 0;
        pkt_rd_done        = 0;
        err_clr            = 0;
        rd_ptr             = '0;
        clk_csi_rst_n      = 0;
        model_reset();
        #1;
        chk("rst_wr_en", mem_wr_en, 0);
        chk("rst_wr_addr", mem_wr_addr, 0);
        chk("rst_wr_data", mem_wr_data, 0);
        chk("rst_commit", commit_ptr, 0);
        chk("rst_count", pkt_count, 0);
        chk("rst_avail", pkt_avail, 0);
        chk("rst_ovf", overflow_err, 0);
        chk("rst_full", buf_full, 0);
        chk("rst_afull", buf_afull, 0);
        @(negedge clk_csi);
        @(negedge clk_csi);
        clk_csi_rst_n = 1;
    endtask

    // Monitor: compares registered outputs against the queued expectations.
    always @(posedge clk_csi) begin
        st_t s;
        wr_t w;
        #1;
        if (clk_csi_rst_n && sq.size() > 0) begin
            s = sq.pop_front();
            chk("wr_en", mem_wr_en, s.we);
            chk("commit_ptr", commit_ptr, s.commit);
            chk("pkt_count", pkt_count, s.cnt);
            chk("pkt_avail", pkt_avail, s.avail);
            chk("buf_full", buf_full, s.full);
            chk("buf_afull", buf_afull, s.afull);
            chk("overflow_err", overflow_err, s.ovf);
            if (mem_wr_en === 1'b1) begin
                if (wq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL wr_unexpected: got write addr %0h expected none", mem_wr_addr);
                end else begin
                    w = wq.pop_front();
                    chk("wr_addr", mem_wr_addr, w.addr);
                    chk("wr_data", mem_wr_data, w.data);
                end
            end
        end
    end

    initial begin
        int  left;
        bit  open;
        logic v, pl, fs, rdd, clr;
        logic [4:0] rd;

        #3;
        do_reset();

        // Three-word packet then commit.
        for (int i = 0; i < 3; i++) word();
        cycle(0, '0, 1, 0, 0, tb_rd, 0);
        settle();
        chk("p1_commit", commit_ptr, 5'd3);
        chk("p1_count", pkt_count, 8'd1);

        // Abort mid-packet, then the next packet resumes at the committed end.
        for (int i = 0; i < 5; i++) word();
        cycle(0, '0, 0, 1, 0, tb_rd, 0);
        settle();
        chk("abort_count", pkt_count, 8'd1);
        chk("abort_commit", commit_ptr, 5'd3);
        word();
        word();
        cycle(0, '0, 1, 0, 1, 5'd3, 0);
        settle();
        chk("coinc_count", pkt_count, 8'd1);
        cycle(0, '0, 0, 0, 1, 5'd5, 0);
        cycle(0, '0, 0, 0, 1, 5'd5, 0);
        settle();
        chk("underflow_count", pkt_count, 8'd0);
        chk("underflow_avail", pkt_avail, 0);

        // Fill the buffer and overflow it.
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            word();
            if (i == 13) begin settle(); chk("afull_13", buf_afull, 0); end
            if (i == 14) begin settle(); chk("afull_14", buf_afull, 1); end
        end
        settle();
        chk("full_16", buf_full, 1);
        word();
        settle();
        chk("ovf_17", overflow_err, 1);
        chk("full_17", buf_full, 0);
        cycle(0, '0, 1, 0, 0, tb_rd, 0);
        settle();
        chk("ovf_count", pkt_count, 8'd0);
        cycle(0, '0, 0, 0, 0, tb_rd, 1);
        settle();
        chk("err_clr", overflow_err, 0);

        // Pointer wrap: packet from 14 wraps to 1.
        for (int i = 0; i < 14; i++) word();
        cycle(0, '0, 1, 0, 0, tb_rd, 0);
        cycle(0, '0, 0, 0, 1, 5'd14, 0);
        for (int i = 0; i < 4; i++) word();
        cycle(0, '0, 1, 0, 0, tb_rd, 0);
        settle();
        chk("wrap_commit", commit_ptr, 5'd18);

        // Reset mid-packet; next packet starts at 0.
        word();
        word();
        do_reset();
        word();
        cycle(0, '0, 1, 0, 0, tb_rd, 0);
        settle();
        chk("post_rst_commit", commit_ptr, 5'd1);

        // Randomized traffic with a reader draining committed packets.
        do_reset();
        open = 0;
        left = 0;
        for (int c = 0; c < 3000; c++) begin
            v = 0; pl = 0; fs = 0; rdd = 0; clr = 0; rd = tb_rd;
            if (open && $urandom_range(80) == 0) begin
                fs   = 1;
                v    = 1'($urandom_range(1));
                open = 0;
            end else begin
                if (ends.size() > 0 && $urandom_range(5) == 0) begin
                    rdd = 1;
                    rd  = ends.pop_front();
                end
                if (open) begin
                    if (left > 0) begin
                        if ($urandom_range(3) != 0) begin
                            v = 1;
                            left--;
                        end
                    end else begin
                        pl   = 1;
                        open = 0;
                    end
                end else if ($urandom_range(1) == 0) begin
                    open = 1;
                    left = $urandom_range(10, 1);
                end else if ($urandom_range(30) == 0) begin
                    pl = 1;
                end
                clr = ($urandom_range(25) == 0);
            end
            cycle(v, {$urandom, $urandom}, pl, fs, rdd, rd, clr);
        end
        idle(2);
        settle();
        settle();
        chk("sq_drained", 64'(sq.size()), 0);
        chk("wq_drained", 64'(wq.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/csi2tx_packet_buffer_wr.md
CSI2TX_PACKET_BUFFER_WR -- requirements
Module: csi2tx_packet_buffer_wr

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, buffer depth 2^ADDR_W 64-bit words.
REQ-002 SHALL have parameter AFULL_MARGIN, default 16, free-word count at or below which buf_afull asserts.
REQ-003 SHALL have port clk_csi  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port clk_csi_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port forcetxstopmode  input  1  synchronous abort of the packet in progress.
REQ-006 SHALL have port pixel_data64  input  64  packet word from the packet aligner.
REQ-007 SHALL have port pixel_data64_valid  input  1  pixel_data64 qualifier, one word per cycle.
REQ-008 SHALL have port packet_incr_pulse  input  1  single-cycle end-of-packet marker, arriving after the packet's last valid word.
REQ-009 SHALL have port rd_ptr  input  ADDR_W+1  reader pointer, with wrap bit, same clock domain.
REQ-010 SHALL have port pkt_rd_done  input  1  single-cycle pulse; reader has consumed one packet.
REQ-011 SHALL have port mem_wr_en  output  1  RAM write strobe.
REQ-012 SHALL have port mem_wr_addr  output  ADDR_W  RAM write address.
REQ-013 SHALL have port mem_wr_data  output  64  RAM write data.
REQ-014 SHALL have port commit_ptr  output  ADDR_W+1  end of the last complete packet; the reader SHALL NOT read beyond it.
REQ-015 SHALL have port pkt_count  output  8  complete packets held in the buffer.
REQ-016 SHALL have port pkt_avail  output  1  pkt_count != 0.
REQ-017 SHALL have port buf_full  output  1  buffer full.
REQ-018 SHALL have port buf_afull  output  1  buffer almost full.
REQ-019 SHALL have port overflow_err  output  1  sticky; set when a packet is dropped.
REQ-020 SHALL have port err_clr  input  1  clears overflow_err.

Function
REQ-021 SHALL keep wr_ptr (ADDR_W+1 bits); level = (wr_ptr - rd_ptr) mod 2^(ADDR_W+1); buf_full = (level == 2^ADDR_W); buf_afull = (2^ADDR_W - level <= AFULL_MARGIN); both combinational from registers.
REQ-022 SHALL implement states IDLE, WRITE, DROP.
REQ-023 IDLE: a valid word with !buf_full SHALL be written and move the state to WRITE; with buf_full it SHALL move the state to DROP and set overflow_err.
REQ-024 WRITE: each valid word with !buf_full SHALL be written and increment wr_ptr, wrapping naturally.
REQ-025 WRITE: a valid word with buf_full SHALL rewind wr_ptr to commit_ptr, set overflow_err, and move the state to DROP.
REQ-026 WRITE: packet_incr_pulse SHALL set commit_ptr to wr_ptr (including any write in the same cycle), increment pkt_count, and return the state to IDLE.
REQ-027 DROP: valid words SHALL be ignored; packet_incr_pulse SHALL return the state to IDLE with no pkt_count change.
REQ-028 IDLE: packet_incr_pulse with no preceding word SHALL be ignored.
REQ-029 A write SHALL assert mem_wr_en, mem_wr_addr = wr_ptr[ADDR_W-1:0] and mem_wr_data one cycle after the accepted valid (registered).
REQ-030 pkt_count SHALL be +1 on commit, -1 on pkt_rd_done, and unchanged when both occur in the same cycle.
REQ-031 pkt_count SHALL saturate at 255; pkt_rd_done at 0 SHALL be ignored.
REQ-032 pkt_avail SHALL be registered alongside pkt_count, with no extra latency.
REQ-033 forcetxstopmode SHALL, next edge, set wr_ptr = commit_ptr and state = IDLE, keep pkt_count and commit_ptr, suppress that cycle's write, and override all other events.
REQ-034 err_clr SHALL clear overflow_err next cycle; when err_clr and a set event coincide, the set event SHALL win.

Reset
REQ-035 Asynchronous reset SHALL set state IDLE; wr_ptr, commit_ptr, pkt_count, mem_wr_addr, mem_wr_data = 0; mem_wr_en, pkt_avail, overflow_err = 0; buf_full follows the pointers (0 when rd_ptr = 0).

Verification (ADDR_W=4, AFULL_MARGIN=2)
REQ-036 Send 3 words, then pulse -> mem_wr_en on 3 cycles at addr 0,1,2; commit_ptr = 3; pkt_count = 1 one cycle after the pulse.
REQ-037 rd_ptr = 0, write 16 words -> buf_full = 1, buf_afull = 1 from the 14th word; a 17th word -> overflow_err = 1, wr_ptr = 0, the pulse leaves pkt_count = 0.
REQ-038 forcetxstopmode after 5 words of the 2nd packet (commit_ptr = 3) -> wr_ptr = 3, state IDLE, pkt_count unchanged.
REQ-039 pkt_count = 1 with pulse and pkt_rd_done coincident -> pkt_count stays 1; then pkt_rd_done twice -> 0, pkt_avail = 0, no underflow.
REQ-040 rd_ptr = 14, wr_ptr = 14, 4-word packet -> addresses 14,15,0,1; commit_ptr = 18 (wrap bit set).
REQ-041 Assert reset mid-packet -> all outputs at reset values immediately; the next packet is written from addr 0.
